// File: rtl/enemy_fire_pkg.sv
// Shared types and defaults for the enemy fire scheduler.
package enemy_fire_pkg;

  localparam int unsigned POS_W_DEFAULT = 11;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArb      = 2'd1,
    StLaunch   = 2'd2,
    StCooldown = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  // One extra bit so ptr + k never overflows before the explicit wrap.
  logic [IdxW:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < int'(N); k++) begin
      pos = {1'b0, ptr} + (IdxW + 1)'(k);
      if (pos >= (IdxW + 1)'(N)) begin
        pos = pos - (IdxW + 1)'(N);
      end
      if (!valid && req[pos[IdxW-1:0]]) begin
        valid                  = 1'b1;
        idx                    = pos[IdxW-1:0];
        grant[pos[IdxW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Grants one requesting enemy a free projectile slot, pulses the launch, then holds off
// further launches for a global cooldown.
module enemy_fire_scheduler
  import enemy_fire_pkg::*;
#(
  parameter int unsigned N_ENEMIES = 4,
  parameter int unsigned N_SLOTS   = 2,
  parameter int unsigned POS_W     = POS_W_DEFAULT,
  parameter int unsigned COOLDOWN  = 10000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_ENEMIES-1:0]         fire_req,
  input  logic [N_ENEMIES*POS_W-1:0]   enemy_posX,
  input  logic [N_ENEMIES*POS_W-1:0]   enemy_posY,
  input  logic [N_SLOTS-1:0]           slot_busy,
  output logic [N_SLOTS-1:0]           launch,
  output logic [POS_W-1:0]             launch_X,
  output logic [POS_W-1:0]             launch_Y,
  output logic [N_ENEMIES-1:0]         fire_ack,
  output logic                         cooldown_on
);

  localparam int unsigned PtrW = $clog2(N_ENEMIES);
  localparam int unsigned CntW = $clog2(COOLDOWN + 1);

  state_e               state_q, state_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      grant_q, grant_d;
  logic [PtrW-1:0]      ptr_inc;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N_SLOTS-1:0]   launch_q, launch_d;
  logic [N_ENEMIES-1:0] fire_ack_q, fire_ack_d;
  logic [POS_W-1:0]     launch_x_q, launch_x_d;
  logic [POS_W-1:0]     launch_y_q, launch_y_d;
  logic                 cooldown_q;

  logic [N_ENEMIES-1:0] arb_grant;
  logic [PtrW-1:0]      arb_idx;
  logic                 arb_valid;
  logic [N_SLOTS-1:0]   slot_oh;
  logic                 slot_free;
  logic [POS_W-1:0]     pos_x, pos_y;

  rr_arbiter #(
    .N (N_ENEMIES)
  ) u_rr_arbiter (
    .req   (fire_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Descending scan so the lowest free slot wins.
  always_comb begin
    slot_oh = '0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        slot_oh    = '0;
        slot_oh[i] = 1'b1;
      end
    end
    slot_free = ~&slot_busy;
  end

  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < int'(N_ENEMIES); i++) begin
      if (arb_idx == PtrW'(i)) begin
        pos_x = enemy_posX[i*POS_W +: POS_W];
        pos_y = enemy_posY[i*POS_W +: POS_W];
      end
    end
  end

  assign ptr_inc = (grant_q == PtrW'(N_ENEMIES - 1)) ? '0 : grant_q + PtrW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    launch_d   = '0;
    fire_ack_d = '0;
    launch_x_d = launch_x_q;
    launch_y_d = launch_y_q;

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      // A pulse already on the outputs still counts as granted.
      if (state_q == StLaunch) begin
        rr_ptr_d = ptr_inc;
      end
    end else begin
      case (state_q)
        StIdle: state_d = StArb;
        StArb: begin
          if (arb_valid && slot_free) begin
            grant_d    = arb_idx;
            launch_d   = slot_oh;
            fire_ack_d = arb_grant;
            launch_x_d = pos_x;
            launch_y_d = pos_y;
            state_d    = StLaunch;
          end
        end
        StLaunch: begin
          rr_ptr_d = ptr_inc;
          cnt_d    = '0;
          state_d  = StCooldown;
        end
        StCooldown: begin
          if (cnt_q == CntW'(COOLDOWN - 1)) begin
            cnt_d   = '0;
            state_d = StArb;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      cnt_q      <= '0;
      launch_q   <= '0;
      fire_ack_q <= '0;
      launch_x_q <= '0;
      launch_y_q <= '0;
      cooldown_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      launch_q   <= launch_d;
      fire_ack_q <= fire_ack_d;
      launch_x_q <= launch_x_d;
      launch_y_q <= launch_y_d;
      cooldown_q <= (state_d == StCooldown);
    end
  end

  assign launch      = launch_q;
  assign fire_ack    = fire_ack_q;
  assign launch_X    = launch_x_q;
  assign launch_Y    = launch_y_q;
  assign cooldown_on = cooldown_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler with N_ENEMIES=4, N_SLOTS=2, COOLDOWN=4.
module tb_enemy_fire_scheduler;

  localparam int unsigned NE = 4;
  localparam int unsigned NS = 2;
  localparam int unsigned PW = 11;
  localparam int unsigned CD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [NE-1:0]     fire_req;
  logic [NE*PW-1:0]  enemy_posX;
  logic [NE*PW-1:0]  enemy_posY;
  logic [NS-1:0]     slot_busy;
  logic [NS-1:0]     launch;
  logic [PW-1:0]     launch_X;
  logic [PW-1:0]     launch_Y;
  logic [NE-1:0]     fire_ack;
  logic              cooldown_on;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] px [NE];
  logic [PW-1:0] py [NE];

  enemy_fire_scheduler #(
    .N_ENEMIES (NE),
    .N_SLOTS   (NS),
    .POS_W     (PW),
    .COOLDOWN  (CD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fire_req    (fire_req),
    .enemy_posX  (enemy_posX),
    .enemy_posY  (enemy_posY),
    .slot_busy   (slot_busy),
    .launch      (launch),
    .launch_X    (launch_X),
    .launch_Y    (launch_Y),
    .fire_ack    (fire_ack),
    .cooldown_on (cooldown_on)
  );

  always #5 clk = ~clk;

  // Waits (bounded) on falling edges until a launch pulse is visible.
  task automatic wait_pulse(input int max_cyc, output int n, output bit seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (launch != '0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (launch !== '0 || fire_ack !== '0 || launch_X !== '0 || launch_Y !== '0 ||
          cooldown_on !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: launch=%b ack=%b X=%0d Y=%0d cd=%b, required all zero",
                 launch, fire_ack, launch_X, launch_Y, cooldown_on);
      end
      enable    = 1'($urandom);
      fire_req  = NE'($urandom);
      slot_busy = NS'($urandom);
    end
    @(negedge clk);
    enable    = 1'b0;
    fire_req  = 4'b1111;
    slot_busy = '0;
    reset     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (launch !== '0 || fire_ack !== '0 || cooldown_on !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: launch=%b ack=%b cd=%b, required 00/0000/0",
                 launch, fire_ack, cooldown_on);
      end
    end
  endtask

  task automatic test_single();
    fire_req = 4'b0100;
    enable   = 1'b1;
    @(negedge clk);
    checks++;
    if (launch !== '0) begin
      errors++;
      $display("FAIL single_arb_cycle: launch=%b, required 00", launch);
    end
    @(negedge clk);
    checks++;
    if (launch !== 2'b01 || fire_ack !== 4'b0100 || launch_X !== 11'd100 ||
        launch_Y !== 11'd50 || cooldown_on !== 1'b0) begin
      errors++;
      $display("FAIL single_launch: launch=%b ack=%b X=%0d Y=%0d cd=%b, required 01 0100 100 50 0",
               launch, fire_ack, launch_X, launch_Y, cooldown_on);
    end
    fire_req = '0;
    for (int c = 0; c < int'(CD); c++) begin
      @(negedge clk);
      checks++;
      if (cooldown_on !== 1'b1 || launch !== '0 || fire_ack !== '0) begin
        errors++;
        $display("FAIL single_cooldown[%0d]: cd=%b launch=%b ack=%b, required 1 00 0000",
                 c, cooldown_on, launch, fire_ack);
      end
    end
    @(negedge clk);
    checks++;
    if (cooldown_on !== 1'b0 || launch_X !== 11'd100 || launch_Y !== 11'd50) begin
      errors++;
      $display("FAIL single_after: cd=%b X=%0d Y=%0d, required 0 100 50",
               cooldown_on, launch_X, launch_Y);
    end
  endtask

  task automatic test_round_robin();
    int            n;
    bit            seen;
    logic [NE-1:0] exp_ack;
    reset    = 1'b0;
    enable   = 1'b0;
    fire_req = '0;
    @(negedge clk);
    reset     = 1'b1;
    enable    = 1'b1;
    fire_req  = 4'b1111;
    slot_busy = '0;
    for (int k = 0; k < 5; k++) begin
      wait_pulse((k == 0) ? 4 : 12, n, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rr_timeout[%0d]: no launch within bound, required a launch", k);
      end
      if (k > 0) begin
        checks++;
        if (n != 6) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: gap=%0d cycles, required 6", k, n);
        end
      end
      exp_ack          = '0;
      exp_ack[k % 4]   = 1'b1;
      checks++;
      if (fire_ack !== exp_ack || launch !== 2'b01 || launch_X !== px[k % 4] ||
          launch_Y !== py[k % 4]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ack=%b launch=%b X=%0d Y=%0d, required %b 01 %0d %0d",
                 k, fire_ack, launch, launch_X, launch_Y, exp_ack, px[k % 4], py[k % 4]);
      end
    end
    fire_req = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_slots();
    int n;
    bit seen;
    fire_req  = 4'b0010;
    slot_busy = 2'b01;
    wait_pulse(4, n, seen);
    checks++;
    if (!seen || launch !== 2'b10 || fire_ack !== 4'b0010) begin
      errors++;
      $display("FAIL slot_skip_busy: seen=%b launch=%b ack=%b, required 1 10 0010",
               seen, launch, fire_ack);
    end
    fire_req  = '0;
    slot_busy = '0;
    repeat (6) @(negedge clk);
    slot_busy = 2'b11;
    fire_req  = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (launch !== '0 || fire_ack !== '0 || cooldown_on !== 1'b0) begin
        errors++;
        $display("FAIL slots_full[%0d]: launch=%b ack=%b cd=%b, required 00 0000 0",
                 c, launch, fire_ack, cooldown_on);
      end
    end
    slot_busy = 2'b10;
    @(negedge clk);
    checks++;
    if (launch !== 2'b01 || fire_ack !== 4'b0100 || launch_X !== px[2]) begin
      errors++;
      $display("FAIL slot_freed: launch=%b ack=%b X=%0d, required 01 0100 %0d",
               launch, fire_ack, launch_X, px[2]);
    end
  endtask

  task automatic test_disable();
    @(negedge clk);
    checks++;
    if (cooldown_on !== 1'b1) begin
      errors++;
      $display("FAIL disable_pre_cd: cd=%b, required 1", cooldown_on);
    end
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (launch !== '0 || fire_ack !== '0 || cooldown_on !== 1'b0) begin
        errors++;
        $display("FAIL disabled[%0d]: launch=%b ack=%b cd=%b, required 00 0000 0",
                 c, launch, fire_ack, cooldown_on);
      end
    end
    slot_busy = '0;
    fire_req  = 4'b1111;
    enable    = 1'b1;
    @(negedge clk);
    checks++;
    if (launch !== '0) begin
      errors++;
      $display("FAIL reenable_arb: launch=%b, required 00", launch);
    end
    @(negedge clk);
    checks++;
    if (launch !== 2'b01 || fire_ack !== 4'b1000 || launch_X !== px[3] ||
        launch_Y !== py[3]) begin
      errors++;
      $display("FAIL reenable_grant: launch=%b ack=%b X=%0d Y=%0d, required 01 1000 %0d %0d",
               launch, fire_ack, launch_X, launch_Y, px[3], py[3]);
    end
  endtask

  task automatic test_reset_in_launch();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (launch !== '0 || fire_ack !== '0 || launch_X !== '0 || launch_Y !== '0 ||
        cooldown_on !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: launch=%b ack=%b X=%0d Y=%0d cd=%b, required all zero",
               launch, fire_ack, launch_X, launch_Y, cooldown_on);
    end
    enable = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (launch !== '0) begin
      errors++;
      $display("FAIL post_reset_arb: launch=%b, required 00", launch);
    end
    @(negedge clk);
    checks++;
    if (launch !== 2'b01 || fire_ack !== 4'b0001 || launch_X !== px[0]) begin
      errors++;
      $display("FAIL post_reset_grant: launch=%b ack=%b X=%0d, required 01 0001 %0d",
               launch, fire_ack, launch_X, px[0]);
    end
  endtask

  initial begin
    px = '{11'd7, 11'd200, 11'd100, 11'd2047};
    py = '{11'd300, 11'd1, 11'd50, 11'd1024};
    for (int i = 0; i < int'(NE); i++) begin
      enemy_posX[i*PW +: PW] = px[i];
      enemy_posY[i*PW +: PW] = py[i];
    end
    enable    = 1'b0;
    fire_req  = '0;
    slot_busy = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_slots();
    test_disable();
    test_reset_in_launch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
